bank_arbiter_rr: RTL and testbench

- Parametrised successor to the quad-port bank scheduler.
- Arbitrates PARALLEL diffusion M-module ports onto one BRAM bank that owns the address window [LOWER_ADDR, UPPER_ADDR].
- Uses round-robin grant instead of fixed priority, and drives registered BRAM command outputs.
- Returns read data to the winning lane after RD_LATENCY cycles with a per-lane valid, and asserts per-lane stall (conflict) for losers.

---
 rtl/bank_arbiter_rr.sv | 137 +++++++++++++
 tb/tb_bank_arbiter_rr.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_arbiter_rr.sv
// Round-robin arbiter that maps PARALLEL lanes onto one BRAM bank's address window,
// with registered BRAM commands and a per-lane read-return path. Optional stats: BANK_ARB_STATS_EN.
module bank_arbiter_rr #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int PARALLEL   = 4,
  parameter int LOWER_ADDR = 0,
  parameter int UPPER_ADDR = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PARALLEL-1:0]            req,
  input  logic [PARALLEL-1:0]            write_en,
  input  logic [ADDR_WIDTH*PARALLEL-1:0] addrFM,
  input  logic [DATA_WIDTH*PARALLEL-1:0] dataFM,
  input  logic [DATA_WIDTH-1:0]          data_mem,
  output logic [ADDR_WIDTH-1:0]          addr,
  output logic [DATA_WIDTH-1:0]          data,
  output logic                           mem_en,
  output logic                           write_mem_en,
  output logic [PARALLEL-1:0]            grant,
  output logic [PARALLEL-1:0]            conflict,
  output logic [DATA_WIDTH*PARALLEL-1:0] dataM,
  output logic [PARALLEL-1:0]            rvalid
`ifdef BANK_ARB_STATS_EN
  ,
  output logic [31:0]                    grant_cnt,
  output logic [31:0]                    conflict_cnt
`endif
);

  localparam int PW = $clog2(PARALLEL);
  localparam logic [ADDR_WIDTH-1:0] LO   = ADDR_WIDTH'(LOWER_ADDR);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(UPPER_ADDR - LOWER_ADDR);

  logic [ADDR_WIDTH-1:0] off [PARALLEL];
  logic [PARALLEL-1:0]   elig;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         gidx;
  logic [PW-1:0]         scan;
  logic [PW:0]           scan_sum;
  logic                  found;

  logic [RD_LATENCY:0]   tag_v;
  logic [PW-1:0]         tag_lane [RD_LATENCY+1];

  // A single wrapped subtraction gives both the local address and the window test:
  // addr-LOWER (mod 2^ADDR_WIDTH) <= UPPER-LOWER holds exactly inside the window.
  always_comb begin
    for (int unsigned i = 0; i < PARALLEL; i++) begin
      off[i]  = addrFM[i*ADDR_WIDTH +: ADDR_WIDTH] - LO;
      elig[i] = req[i] && (off[i] <= SPAN);
    end
  end

  always_comb begin
    found    = 1'b0;
    gidx     = '0;
    scan     = '0;
    scan_sum = '0;
    for (int unsigned k = 0; k < PARALLEL; k++) begin
      scan_sum = {1'b0, ptr} + (PW+1)'(k);
      if (scan_sum >= (PW+1)'(PARALLEL))
        scan_sum = scan_sum - (PW+1)'(PARALLEL);
      scan = scan_sum[PW-1:0];
      if (!found && elig[scan]) begin
        found = 1'b1;
        gidx  = scan;
      end
    end
    grant = '0;
    if (found)
      grant[gidx] = 1'b1;
    conflict = elig & ~grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      addr         <= '0;
      data         <= '0;
      mem_en       <= 1'b0;
      write_mem_en <= 1'b0;
      tag_v        <= '0;
      for (int unsigned i = 0; i <= RD_LATENCY; i++)
        tag_lane[i] <= '0;
    end else begin
      mem_en       <= found;
      write_mem_en <= found & write_en[gidx];
      if (found) begin
        ptr  <= (gidx == PW'(PARALLEL-1)) ? '0 : gidx + PW'(1);
        addr <= off[gidx];
        data <= dataFM[32'(gidx)*DATA_WIDTH +: DATA_WIDTH];
      end
      tag_v       <= {tag_v[RD_LATENCY-1:0], found & ~write_en[gidx]};
      tag_lane[0] <= gidx;
      for (int unsigned i = 1; i <= RD_LATENCY; i++)
        tag_lane[i] <= tag_lane[i-1];
    end
  end

  // The final tag stage lines up with the BRAM output word for that command.
  always_comb begin
    rvalid = '0;
    dataM  = '0;
    if (tag_v[RD_LATENCY]) begin
      rvalid[tag_lane[RD_LATENCY]] = 1'b1;
      dataM[32'(tag_lane[RD_LATENCY])*DATA_WIDTH +: DATA_WIDTH] = data_mem;
    end
  end

`ifdef BANK_ARB_STATS_EN
  localparam int CW = $clog2(PARALLEL+1);
  logic [CW-1:0] n_conf;
  logic [32:0]   conf_sum;

  always_comb begin
    n_conf = '0;
    for (int unsigned i = 0; i < PARALLEL; i++)
      n_conf = n_conf + CW'(conflict[i]);
    conf_sum = {1'b0, conflict_cnt} + 33'(n_conf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (found && (grant_cnt != '1))
        grant_cnt <= grant_cnt + 32'd1;
      conflict_cnt <= conf_sum[32] ? '1 : conf_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_bank_arbiter_rr.sv
// Bench for bank_arbiter_rr: two instances (window 0..4 / RD 1, window 8..12 / RD 3),
// scenario tasks with inline checks, and a read-return scoreboard drained every cycle.
module tb_bank_arbiter_rr;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic mon_en;

  typedef struct { int inst; int lane; int due; } rd_t;
  rd_t sb[$];

  logic [3:0]   req0, we0, gr0, cf0, rv0, req1, we1, gr1, cf1, rv1;
  logic [51:0]  a0, a1;
  logic [127:0] df0, df1, dm0, dm1;
  logic [31:0]  dmem0, dmem1, data0, data1;
  logic [12:0]  addr0, addr1;
  logic         me0, wme0, me1, wme1;
`ifdef BANK_ARB_STATS_EN
  logic [31:0]  gc0, cc0, gc1, cc1;
`endif

  function automatic logic [31:0] fdat(int inst, int c);
    return 32'h5A00_0000 ^ (32'(c) * 32'h0001_0203) ^ ((inst == 1) ? 32'hFFFF_0000 : 32'h0);
  endfunction

  assign dmem0 = fdat(0, cyc);
  assign dmem1 = fdat(1, cyc);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bank_arbiter_rr #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .PARALLEL(4),
                    .LOWER_ADDR(0), .UPPER_ADDR(4), .RD_LATENCY(1)) u0 (
    .clk(clk), .rst(rst), .req(req0), .write_en(we0), .addrFM(a0), .dataFM(df0),
    .data_mem(dmem0), .addr(addr0), .data(data0), .mem_en(me0), .write_mem_en(wme0),
    .grant(gr0), .conflict(cf0), .dataM(dm0), .rvalid(rv0)
`ifdef BANK_ARB_STATS_EN
    , .grant_cnt(gc0), .conflict_cnt(cc0)
`endif
  );

  bank_arbiter_rr #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .PARALLEL(4),
                    .LOWER_ADDR(8), .UPPER_ADDR(12), .RD_LATENCY(3)) u1 (
    .clk(clk), .rst(rst), .req(req1), .write_en(we1), .addrFM(a1), .dataFM(df1),
    .data_mem(dmem1), .addr(addr1), .data(data1), .mem_en(me1), .write_mem_en(wme1),
    .grant(gr1), .conflict(cf1), .dataM(dm1), .rvalid(rv1)
`ifdef BANK_ARB_STATS_EN
    , .grant_cnt(gc1), .conflict_cnt(cc1)
`endif
  );

  // Move to the sampling point of the current cycle and retire scoreboard entries due now.
  task automatic half();
    logic [3:0]   erv;
    logic [127:0] edm;
    logic [3:0]   arv;
    logic [127:0] adm;
    @(negedge clk);
    if (mon_en) begin
      for (int j = 0; j < 2; j++) begin
        erv = '0;
        edm = '0;
        foreach (sb[k]) begin
          if (sb[k].inst == j && sb[k].due == cyc) begin
            erv[sb[k].lane] = 1'b1;
            edm[sb[k].lane*32 +: 32] = fdat(j, cyc);
          end
        end
        arv = (j == 0) ? rv0 : rv1;
        adm = (j == 0) ? dm0 : dm1;
        n_chk++;
        if (arv !== erv || adm !== edm) begin
          n_fail++;
          $display("FAIL sb_rdata u%0d cyc=%0d got rvalid=%b dataM=%h expected rvalid=%b dataM=%h",
                   j, cyc, arv, adm, erv, edm);
        end
      end
    end
    for (int k = sb.size() - 1; k >= 0; k--)
      if (sb[k].due <= cyc) sb.delete(k);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    half();
    n_chk++;
    if ({addr0, data0, me0, wme0, rv0, dm0, gr0, cf0} !== '0) begin
      n_fail++;
      $display("FAIL reset_u0 got addr=%h data=%h me=%b wme=%b rv=%b gr=%b cf=%b expected all 0",
               addr0, data0, me0, wme0, rv0, gr0, cf0);
    end
    n_chk++;
    if ({addr1, data1, me1, wme1, rv1, dm1, gr1, cf1} !== '0) begin
      n_fail++;
      $display("FAIL reset_u1 got addr=%h data=%h me=%b wme=%b rv=%b gr=%b cf=%b expected all 0",
               addr1, data1, me1, wme1, rv1, gr1, cf1);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      half();
      n_chk++;
      if ({me0, wme0, me1, wme1} !== 4'b0000) begin
        n_fail++;
        $display("FAIL idle_mem_en got %b expected 0000", {me0, wme0, me1, wme1});
      end
    end
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    req0 = 4'hF;
    we0  = 4'h0;
    a0   = {4{13'd1}};
    df0  = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
    for (int i = 0; i < 5; i++) begin
      exp = 4'b0001 << (i % 4);
      half();
      n_chk++;
      if (gr0 !== exp || cf0 !== ~exp) begin
        n_fail++;
        $display("FAIL rr_grant i=%0d got grant=%b conflict=%b expected grant=%b conflict=%b",
                 i, gr0, cf0, exp, ~exp);
      end
      sb.push_back('{0, i % 4, cyc + 2});
      if (i > 0) begin
        n_chk++;
        if (addr0 !== 13'd1 || me0 !== 1'b1 || wme0 !== 1'b0 || data0 !== 32'h1000 + 32'((i - 1) % 4)) begin
          n_fail++;
          $display("FAIL rr_cmd i=%0d got addr=%0d me=%b wme=%b data=%h expected 1 1 0 %h",
                   i, addr0, me0, wme0, data0, 32'h1000 + 32'((i - 1) % 4));
        end
      end
      step();
    end
    req0 = 4'h0;
    half();
    n_chk++;
    if (addr0 !== 13'd1 || me0 !== 1'b1 || data0 !== 32'h1000) begin
      n_fail++;
      $display("FAIL rr_last_cmd got addr=%0d me=%b data=%h expected 1 1 00001000", addr0, me0, data0);
    end
    step();
    half();
    step();
  endtask

  task automatic test_single_read();
    req0 = 4'b0100;
    we0  = 4'b0000;
    a0   = {13'd0, 13'd3, 13'd0, 13'd0};
    half();
    n_chk++;
    if (gr0 !== 4'b0100 || cf0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_grant got grant=%b conflict=%b expected 0100 0000", gr0, cf0);
    end
    sb.push_back('{0, 2, cyc + 2});
    step();
    req0 = 4'b0000;
    half();
    n_chk++;
    if (addr0 !== 13'd3 || me0 !== 1'b1 || wme0 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_cmd got addr=%0d me=%b wme=%b expected 3 1 0", addr0, me0, wme0);
    end
    step();
    half();
    step();
  endtask

  task automatic test_mixed_rw();
    req0 = 4'b1011;
    we0  = 4'b0001;
    a0   = {13'd5, 13'd0, 13'd4, 13'd2};
    df0  = {32'h0, 32'h0, 32'h1111_2222, 32'hAAAA_5555};
    half();
    n_chk++;
    if (gr0 !== 4'b0001 || cf0 !== 4'b0010) begin
      n_fail++;
      $display("FAIL mixed_grant1 got grant=%b conflict=%b expected 0001 0010", gr0, cf0);
    end
    step();
    req0 = 4'b1010;
    half();
    n_chk++;
    if (gr0 !== 4'b0010 || cf0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL mixed_grant2 got grant=%b conflict=%b expected 0010 0000", gr0, cf0);
    end
    n_chk++;
    if (addr0 !== 13'd2 || data0 !== 32'hAAAA_5555 || wme0 !== 1'b1 || me0 !== 1'b1) begin
      n_fail++;
      $display("FAIL mixed_wr_cmd got addr=%0d data=%h wme=%b me=%b expected 2 aaaa5555 1 1",
               addr0, data0, wme0, me0);
    end
    sb.push_back('{0, 1, cyc + 2});
    step();
    req0 = 4'b0000;
    half();
    n_chk++;
    if (addr0 !== 13'd4 || wme0 !== 1'b0 || me0 !== 1'b1) begin
      n_fail++;
      $display("FAIL mixed_rd_cmd got addr=%0d wme=%b me=%b expected 4 0 1", addr0, wme0, me0);
    end
    step();
    half();
    n_chk++;
    if (me0 !== 1'b0 || wme0 !== 1'b0 || addr0 !== 13'd4 || data0 !== 32'h1111_2222) begin
      n_fail++;
      $display("FAIL idle_hold got me=%b wme=%b addr=%0d data=%h expected 0 0 4 11112222",
               me0, wme0, addr0, data0);
    end
    step();
  endtask

  task automatic test_window();
    req1 = 4'b0011;
    we1  = 4'b0011;
    a1   = {13'd0, 13'd0, 13'd12, 13'd13};
    df1  = {32'h0, 32'h0, 32'h55, 32'h99};
    half();
    n_chk++;
    if (gr1 !== 4'b0010 || cf1 !== 4'b0000) begin
      n_fail++;
      $display("FAIL window_grant got grant=%b conflict=%b expected 0010 0000", gr1, cf1);
    end
    step();
    req1 = 4'b0000;
    half();
    n_chk++;
    if (addr1 !== 13'd4 || data1 !== 32'h55 || wme1 !== 1'b1 || me1 !== 1'b1) begin
      n_fail++;
      $display("FAIL window_cmd got addr=%0d data=%h wme=%b me=%b expected 4 00000055 1 1",
               addr1, data1, wme1, me1);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      half();
      step();
    end
  endtask

  task automatic test_reset_midflight();
    req1 = 4'b0010;
    we1  = 4'b0000;
    a1   = {13'd0, 13'd0, 13'd9, 13'd0};
    half();
    n_chk++;
    if (gr1 !== 4'b0010) begin
      n_fail++;
      $display("FAIL midflight_grant got grant=%b expected 0010", gr1);
    end
    sb.push_back('{1, 1, cyc + 4});
    step();
    req1 = 4'b0000;
    half();
    step();
    rst = 1'b1;
    sb.delete();
    half();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      half();
      n_chk++;
      if (rv1 !== 4'b0000) begin
        n_fail++;
        $display("FAIL midflight_rvalid i=%0d got %b expected 0000", i, rv1);
      end
      step();
    end
    req1 = 4'hF;
    a1   = {4{13'd8}};
    half();
    n_chk++;
    if (gr1 !== 4'b0001 || cf1 !== 4'b1110) begin
      n_fail++;
      $display("FAIL ptr_after_reset got grant=%b conflict=%b expected 0001 1110", gr1, cf1);
    end
    sb.push_back('{1, 0, cyc + 4});
    step();
    req1 = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      half();
      step();
    end
  endtask

`ifdef BANK_ARB_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    half();
    step();
    rst  = 1'b0;
    req0 = 4'b0111;
    we0  = 4'b0111;
    a0   = '0;
    for (int k = 0; k < 3; k++) begin
      half();
      step();
      req0[k] = 1'b0;
    end
    half();
    n_chk++;
    if (gc0 !== 32'd3 || cc0 !== 32'd3) begin
      n_fail++;
      $display("FAIL stats got grant_cnt=%0d conflict_cnt=%0d expected 3 3", gc0, cc0);
    end
    step();
  endtask
`endif

  initial begin
    mon_en = 1'b0;
    rst  = 1'b1;
    req0 = '0; we0 = '0; a0 = '0; df0 = '0;
    req1 = '0; we1 = '0; a1 = '0; df1 = '0;
    test_reset();
    test_round_robin();
    test_single_read();
    test_mixed_rw();
    test_window();
    test_reset_midflight();
`ifdef BANK_ARB_STATS_EN
    test_stats();
`endif
    for (int i = 0; i < 3; i++) begin
      half();
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
